// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: state encoding and board timing defaults.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned BOARD_ON_CYCLES  = 5_000_000;
  localparam int unsigned BOARD_GAP_CYCLES = 2_500_000;

  // Timer width wide enough for the longer of the two load values (min 1 bit).
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_blink_driver_if.sv
// Event-in / LED-status-out bundle for the blink driver.
interface led_blink_driver_if #(
  parameter int unsigned PEND_W = 4
);
  logic              trig;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output trig, input led, busy, pending, overflow);
  modport slave  (input trig, output led, busy, pending, overflow);
endinterface

// File: rtl/led_blink_driver_blink_timer.sv
// Loadable down-counter with a zero flag; holds at zero.
module blink_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_d, count_q;

  // Load takes priority over decrement; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into fixed-length LED blinks separated by a dark gap.
module led_blink_driver
  import led_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = BOARD_ON_CYCLES,
  parameter int unsigned GAP_CYCLES = BOARD_GAP_CYCLES,
  parameter int unsigned PEND_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_blink_driver_if.slave   bus
);

  localparam int unsigned TW = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_d, state_q;
  logic [PEND_W-1:0] pending_d, pending_q;
  logic              led_d, led_q;
  logic              overflow_d, overflow_q;
  logic              consume;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]     tmr_load_val;

  // State, LED and overflow registers; reset forces the LED dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      led_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: the FSM only looks at the pending count, never at trig.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pending_q != '0) state_d = ST_ON;
      ST_ON:   if (tmr_zero)        state_d = ST_GAP;
      ST_GAP:  if (tmr_zero)        state_d = (pending_q != '0) ? ST_ON : ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Outputs of the FSM: event consume, timer control and next LED value.
  always_comb begin
    consume      = (state_d == ST_ON) && (state_q != ST_ON);
    tmr_load     = (state_d != state_q) && (state_d != ST_IDLE);
    tmr_load_val = (state_d == ST_ON) ? ON_LOAD : GAP_LOAD;
    tmr_dec      = (state_q != ST_IDLE) && !tmr_load;
    led_d        = (state_d == ST_ON);
  end

  // Pending counter: saturating, with a drop flagged on overflow the next cycle.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = 1'b0;
    if (bus.trig && !consume) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 1'b1;
    end else if (!bus.trig && consume) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Pending counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  blink_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign bus.led      = led_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Output-side counterpart to the button input synchronizer. It turns single-cycle, clock-synchronous event pulses from core logic into human-visible LED blinks. Each accepted event produces exactly one blink of fixed length, followed by a guaranteed dark gap. Events that arrive while a blink is in progress are queued in a saturating pending counter, and the block reports any events it drops.

## Interface
Parameters:
- `ON_CYCLES`, default 5_000_000: LED-on duration per blink in clock cycles; must be ≥ 1.
- `GAP_CYCLES`, default 2_500_000: minimum LED-off duration between blinks in clock cycles; must be ≥ 1.
- `PEND_W`, default 4: width of the pending-event counter; the counter saturates at 2^PEND_W−1.

Ports:
- `clk`  input  1: the single clock.
- `rst`  input  1: reset, asynchronous and active-high.
- `trig`  input  1: event strobe, synchronous to `clk`; each sampled-high cycle is one event.
- `led`  output  1: registered LED drive; 1 = lit.
- `busy`  output  1: 1 while a blink is active or events are pending.
- `pending`  output  PEND_W: number of queued, unserviced events.
- `overflow`  output  1: one-cycle pulse for each event dropped at saturation.

## Operation
- FSM states and exit conditions:
  - IDLE: go to ON when `pending` ≠ 0.
  - ON: go to GAP when the timer reaches 0.
  - GAP: when the timer reaches 0, go to ON if `pending` ≠ 0, otherwise go to IDLE.
- Timer:
  - Width is $clog2(max(ON_CYCLES, GAP_CYCLES)).
  - Loaded with ON_CYCLES−1 on entry to ON and with GAP_CYCLES−1 on entry to GAP.
  - Decrements by 1 in every other cycle spent in ON or GAP.
- Pending counter:
  - +1 when `trig` = 1.
  - −1 on every transition into ON (the event is consumed).
  - Increment and decrement in the same cycle leave it unchanged.
  - When it is at 2^PEND_W−1 and `trig` = 1 with no consume that cycle: the event is dropped and `overflow` = 1 for the following cycle.
- Events enter through `pending` only. The FSM never acts on `trig` directly.
- `led` is a dedicated flop that is 1 exactly while the state is ON. It must be glitch-free.
- `busy` = (state ≠ IDLE) or (`pending` ≠ 0).
- Reset values: state IDLE, timer 0, `pending` 0, `led` 0, `overflow` 0, `busy` 0.
- Reset asserted mid-blink: `led` drops immediately (asynchronously). All queued events are discarded.
- Reset release: the first `trig` sampled after release is serviced normally.

## Timing
- `trig` sampled at edge N → `pending` = 1 after edge N.
- Edge N+1 → state ON, `led` = 1, `pending` decremented.
- Latency from the `trig` edge to `led` rising is 2 edges.
- `led` stays high for exactly ON_CYCLES cycles.
- The gap is exactly GAP_CYCLES cycles. Back-to-back blinks rise ON_CYCLES+GAP_CYCLES cycles apart.
- After the last blink, `busy` falls at the edge where GAP exits to IDLE.
- `overflow` rises one edge after the dropped `trig` and lasts one cycle per dropped event.

## Structure
- Shared package `led_pkg` holds:
  - the state encoding (IDLE, ON, GAP, 2-bit);
  - default cycle constants for the board clock.
- One sub-module: `blink_timer`, a loadable down-counter with a zero flag. It is parameterized by width and is reusable for other display timing.
- The input synchronizer stays upstream. This block assumes `trig` is already synchronous to `clk`.

## Test plan
All scenarios use ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2.
- **Single event:** `trig` high at edge 10 → `led` = 1 after edges 11–14, 0 after edge 15; state IDLE and `busy` = 0 after edge 18.
- **Back-to-back events:** `trig` high at edges 10, 11, 12 → `led` rises after edges 11, 18 and 25, each time for 4 cycles; `pending` reads 1, 1, 2 after edges 10, 11, 12; `overflow` never asserts.
- **Saturation:** `trig` held high for edges 10–15 → `pending` reaches 3 at edge 13; `overflow` pulses after edges 14 and 15; exactly 4 blinks occur in total.
- **Simultaneous increment and consume:** `trig` coincides with the GAP→ON edge while `pending` = 2 → `pending` stays 2 and `led` rises on schedule.
- **Reset mid-blink:** `rst` asserted between edges 12 and 13 → `led`, `pending` and `busy` go to 0 immediately, without waiting for a clock edge; after release, `trig` at edge 30 → `led` rises after edge 31.
- **Idle stability:** no `trig` for 100 cycles after reset → `led`, `busy` and `overflow` stay 0 and `pending` stays 0.
